// File: rtl/alu_exec_pkg.sv
// rtl/alu_exec_pkg.sv - alu_op/funct3/funct7 encodings and FSM state type for the RV32I execution unit.
package alu_exec_pkg;

   localparam logic [1:0] ALU_OP_ADD = 2'b00;
   localparam logic [1:0] ALU_OP_SUB = 2'b01;
   localparam logic [1:0] ALU_OP_R   = 2'b10;
   localparam logic [1:0] ALU_OP_I   = 2'b11;

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SR   = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SHIFT = 2'b01,
      DONE  = 2'b10
   } state_t;

   function automatic logic f3_is_shift(input logic [2:0] f3);
      return (f3 == F3_SLL) || (f3 == F3_SR);
   endfunction

endpackage

// File: rtl/alu_exec_shifter.sv
// rtl/alu_exec_shifter.sv - shifter for alu_exec: 1 bit/cycle, or single-cycle barrel when ALU_EXEC_FAST_SHIFT_EN is defined.
module alu_exec_shifter #(
   parameter int XLEN    = 32,
   parameter int SHAMT_W = 5
) (
   input  logic               clk,
   input  logic               nreset,
   input  logic               load,
   input  logic               dir,
   input  logic               arith,
   input  logic [SHAMT_W-1:0] shamt,
   input  logic [XLEN-1:0]    din,
   output logic [XLEN-1:0]    dout,
   output logic               busy,
   output logic               done
);

`ifdef ALU_EXEC_FAST_SHIFT_EN

   logic [XLEN-1:0] data;
   logic [XLEN-1:0] barrel;

   always_comb begin
      barrel = din << shamt;
      if (dir) begin
         if (arith) barrel = XLEN'($signed(din) >>> shamt);
         else       barrel = din >> shamt;
      end
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset)   data <= '0;
      else if (load) data <= barrel;
   end

   // Result is available in the load cycle itself; the register only holds it afterwards.
   assign dout = load ? barrel : data;
   assign busy = 1'b0;
   assign done = load;

`else

   logic [XLEN-1:0]    data;
   logic [XLEN-1:0]    step;
   logic [SHAMT_W-1:0] cnt;
   logic               dir_q;
   logic               arith_q;

   // Right shifts fill with the sign bit only for SRA; data[XLEN-1] never changes during SRA.
   always_comb begin
      if (dir_q) step = {arith_q & data[XLEN-1], data[XLEN-1:1]};
      else       step = {data[XLEN-2:0], 1'b0};
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         data    <= '0;
         cnt     <= '0;
         dir_q   <= 1'b0;
         arith_q <= 1'b0;
      end else if (load) begin
         data    <= din;
         cnt     <= shamt;
         dir_q   <= dir;
         arith_q <= arith;
      end else if (cnt != '0) begin
         data <= step;
         cnt  <= cnt - 1'b1;
      end
   end

   // dout is the value after this cycle's step, so done marks the final step's edge.
   assign dout = step;
   assign busy = (cnt != '0);
   assign done = (cnt == SHAMT_W'(1));

`endif

endmodule

// File: rtl/alu_exec.sv
// rtl/alu_exec.sv - RV32I integer ALU with valid/ready handshake; ALU_EXEC_FAST_SHIFT_EN selects the barrel shifter.
module alu_exec
   import alu_exec_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int SHAMT_W = 5
) (
   input  logic            clk,
   input  logic            nreset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [1:0]      alu_op,
   input  logic [2:0]      funct3,
   input  logic [6:0]      funct7,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            zero,
   output logic            illegal
);

   state_t          state, state_nxt;
   logic            accept;
   logic [XLEN-1:0] res;
   logic [XLEN-1:0] shift_res;
   logic            ill;
   logic            is_r;
   logic            f7_ok;
   logic            is_shift;
   logic            shift_go;
   logic [XLEN-1:0] sh_dout;
   logic            sh_busy;
   logic            sh_done;

   assign accept = in_valid && in_ready;

`ifdef ALU_EXEC_FAST_SHIFT_EN
   assign shift_res = sh_dout;
   assign shift_go  = 1'b0;
`else
   // Zero shift amount completes like any single-cycle op with result = op_a.
   assign shift_res = op_a;
   assign shift_go  = is_shift && (op_b[SHAMT_W-1:0] != '0);
`endif

   always_comb begin
      res      = '0;
      ill      = 1'b0;
      is_shift = 1'b0;
      is_r     = (alu_op == ALU_OP_R);
      f7_ok    = (funct7 == F7_BASE) || (funct7 == F7_ALT);
      case (alu_op)
         ALU_OP_ADD: res = op_a + op_b;
         ALU_OP_SUB: res = op_a - op_b;
         default: begin
            if (is_r)
               ill = !f7_ok || ((funct7 == F7_ALT) && !((funct3 == F3_ADD) || (funct3 == F3_SR)));
            else if (f3_is_shift(funct3))
               ill = !f7_ok || ((funct3 == F3_SLL) && (funct7 == F7_ALT));
            case (funct3)
               F3_ADD:  res = (is_r && (funct7 == F7_ALT)) ? op_a - op_b : op_a + op_b;
               F3_SLT:  res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
               F3_SLTU: res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
               F3_XOR:  res = op_a ^ op_b;
               F3_OR:   res = op_a | op_b;
               F3_AND:  res = op_a & op_b;
               default: begin
                  is_shift = 1'b1;
                  res      = shift_res;
               end
            endcase
            if (ill) begin
               res      = '0;
               is_shift = 1'b0;
            end
         end
      endcase
   end

   alu_exec_shifter #(
      .XLEN    (XLEN),
      .SHAMT_W (SHAMT_W)
   ) u_shifter (
      .clk    (clk),
      .nreset (nreset),
      .load   (accept && is_shift),
      .dir    (funct3[2]),
      .arith  (funct7[5]),
      .shamt  (op_b[SHAMT_W-1:0]),
      .din    (op_a),
      .dout   (sh_dout),
      .busy   (sh_busy),
      .done   (sh_done)
   );

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) state <= IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = shift_go ? SHIFT : DONE;
         SHIFT:   if (sh_done || !sh_busy) state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state == IDLE);
      out_valid = (state == DONE);
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         result  <= '0;
         zero    <= 1'b1;
         illegal <= 1'b0;
      end else if (accept) begin
         result  <= res;
         zero    <= (res == '0);
         illegal <= ill;
      end else if ((state == SHIFT) && sh_done) begin
         result <= sh_dout;
         zero   <= (sh_dout == '0);
      end
   end

endmodule

// File: tb/tb_alu_exec.sv
// tb/tb_alu_exec.sv - directed self-checking bench for alu_exec (honours ALU_EXEC_FAST_SHIFT_EN).
module tb_alu_exec;

   logic        clk = 1'b0;
   logic        nreset = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [1:0]  alu_op = 2'b00;
   logic [2:0]  funct3 = 3'b000;
   logic [6:0]  funct7 = 7'b0000000;
   logic [31:0] op_a = 32'h0;
   logic [31:0] op_b = 32'h0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] result;
   logic        zero;
   logic        illegal;

   int n_checks = 0;
   int n_errors = 0;
   int lat;
   int stable;

`ifdef ALU_EXEC_FAST_SHIFT_EN
   localparam bit FAST = 1'b1;
`else
   localparam bit FAST = 1'b0;
`endif

   alu_exec dut (
      .clk       (clk),
      .nreset    (nreset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .alu_op    (alu_op),
      .funct3    (funct3),
      .funct7    (funct7),
      .op_a      (op_a),
      .op_b      (op_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .zero      (zero),
      .illegal   (illegal)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic int sh_lat(input int shamt);
      return FAST ? 1 : 1 + shamt;
   endfunction

   // Drive one request, return #1 after its accept edge with inputs scrambled.
   task automatic send(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      in_valid = 1'b1;
      alu_op   = op;
      funct3   = f3;
      funct7   = f7;
      op_a     = a;
      op_b     = b;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      alu_op   = 2'($urandom);
      funct3   = 3'($urandom);
      funct7   = 7'($urandom);
      op_a     = $urandom;
      op_b     = $urandom;
   endtask

   task automatic wait_valid(output int l);
      l = 1;
      while (out_valid !== 1'b1 && l < 100) begin
         @(posedge clk);
         #1;
         l++;
      end
   endtask

   task automatic release_result(input string tag);
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk({tag, "/ov_low"}, 32'(out_valid), 32'd0);
      chk({tag, "/in_ready"}, 32'(in_ready), 32'd1);
   endtask

   task automatic run(input string tag, input logic [1:0] op, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] exp_res, input logic exp_ill, input int exp_lat);
      int l;
      send(op, f3, f7, a, b);
      wait_valid(l);
      chk({tag, "/lat"}, 32'(l), 32'(exp_lat));
      chk({tag, "/result"}, result, exp_res);
      chk({tag, "/zero"}, 32'(zero), 32'(exp_res == 32'h0));
      chk({tag, "/illegal"}, 32'(illegal), 32'(exp_ill));
      release_result(tag);
   endtask

   initial begin
      #12;
      chk("rst/in_ready", 32'(in_ready), 32'd1);
      chk("rst/out_valid", 32'(out_valid), 32'd0);
      chk("rst/result", result, 32'h0);
      chk("rst/zero", 32'(zero), 32'd1);
      chk("rst/illegal", 32'(illegal), 32'd0);
      @(negedge clk);
      nreset = 1'b1;

      run("r_sub",      2'b10, 3'b000, 7'b0100000, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0, 1);
      run("op_sub_eq",  2'b01, 3'b111, 7'b1111111, 32'd9, 32'd9, 32'h0, 1'b0, 1);
      run("op_add_wrap",2'b00, 3'b101, 7'b0100000, 32'hFFFF_FFFF, 32'd1, 32'h0, 1'b0, 1);
      run("r_sra31",    2'b10, 3'b101, 7'b0100000, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 1'b0, sh_lat(31));
      run("r_srl31",    2'b10, 3'b101, 7'b0000000, 32'h8000_0000, 32'd31, 32'h0000_0001, 1'b0, sh_lat(31));
      run("i_slli0",    2'b11, 3'b001, 7'b0000000, 32'h0000_1234, 32'hFFFF_FFE0, 32'h0000_1234, 1'b0, 1);
      run("r_sll4",     2'b10, 3'b001, 7'b0000000, 32'h0000_0003, 32'd4, 32'h0000_0030, 1'b0, sh_lat(4));
      run("i_srai4",    2'b11, 3'b101, 7'b0100000, 32'hF000_0000, 32'd4, 32'hFF00_0000, 1'b0, sh_lat(4));
      run("r_sltu",     2'b10, 3'b011, 7'b0000000, 32'd1, 32'hFFFF_FFFF, 32'd1, 1'b0, 1);
      run("r_slt",      2'b10, 3'b010, 7'b0000000, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 1);
      run("i_addi_alt", 2'b11, 3'b000, 7'b0100000, 32'd5, 32'd7, 32'd12, 1'b0, 1);
      run("i_ori",      2'b11, 3'b110, 7'b1010101, 32'h0F0F_0000, 32'h0000_00F0, 32'h0F0F_00F0, 1'b0, 1);
      run("ill_r_f7",   2'b10, 3'b100, 7'b0000001, 32'hFF, 32'h0F, 32'h0, 1'b1, 1);
      run("ill_r_alt",  2'b10, 3'b110, 7'b0100000, 32'hFF, 32'h0F, 32'h0, 1'b1, 1);
      run("ill_slli",   2'b11, 3'b001, 7'b0100000, 32'h1, 32'd3, 32'h0, 1'b1, 1);
      run("ill_srli",   2'b11, 3'b101, 7'b0000010, 32'h80, 32'd3, 32'h0, 1'b1, 1);

      // Backpressure, then a request presented in the same cycle out_ready rises.
      send(2'b11, 3'b111, 7'b0, 32'h0000_F0F0, 32'h0000_FF00);
      wait_valid(lat);
      chk("bp/lat", 32'(lat), 32'd1);
      stable = 1;
      repeat (10) begin
         @(posedge clk);
         #1;
         if (result !== 32'h0000_F000 || out_valid !== 1'b1 || in_ready !== 1'b0) stable = 0;
      end
      chk("bp/stable", 32'(stable), 32'd1);
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      alu_op    = 2'b11;
      funct3    = 3'b100;
      funct7    = 7'b0;
      op_a      = 32'h0000_00FF;
      op_b      = 32'h0000_000F;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk("bp/no_b2b_ov", 32'(out_valid), 32'd0);
      chk("bp/no_b2b_rdy", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("bp/next_ov", 32'(out_valid), 32'd1);
      chk("bp/next_res", result, 32'h0000_00F0);
      release_result("bp/next");

      // Asynchronous reset five cycles into a 20-bit shift.
      send(2'b10, 3'b001, 7'b0, 32'h1, 32'd20);
      chk("rs/busy_rdy", 32'(in_ready), 32'd0);
      repeat (4) @(posedge clk);
      #2;
      nreset = 1'b0;
      #1;
      chk("rs/out_valid", 32'(out_valid), 32'd0);
      chk("rs/in_ready", 32'(in_ready), 32'd1);
      chk("rs/result", result, 32'h0);
      chk("rs/zero", 32'(zero), 32'd1);
      @(negedge clk);
      nreset = 1'b1;
      run("rs/after", 2'b10, 3'b001, 7'b0, 32'h1, 32'd20, 32'h0010_0000, 1'b0, sh_lat(20));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/alu_exec.md
Name: alu_exec

Overview:
- Execution unit on the consumer side of the decode controller's `alu_op` interface.
- Takes `alu_op[1:0]` plus `funct3`/`funct7` and two 32-bit operands, and performs the RV32I integer ALU operation.
- Returns a registered result through a valid/ready handshake.
- Shifts are iterative, 1 bit per cycle, so the block is multi-cycle; all other ops complete in one cycle.

Parameters:
- `XLEN`, default 32: operand/result width (must be 32 for RV32I).
- `SHAMT_W`, default 5: shift-amount width, log2(`XLEN`).

Ports:
- `clk`  in  1  clock
- `nreset`  in  1  asynchronous active-low reset
- `in_valid`  in  1  request valid
- `in_ready`  out  1  block can accept a request
- `alu_op`  in  2  from controller: 00 add, 01 sub, 10 R-type decode, 11 I-type decode
- `funct3`  in  3  instruction funct3
- `funct7`  in  7  instruction funct7 (imm[11:5] for I-type shifts)
- `op_a`  in  `XLEN`  rs1 value
- `op_b`  in  `XLEN`  rs2 value or immediate
- `out_valid`  out  1  result valid
- `out_ready`  in  1  consumer accepts result
- `result`  out  `XLEN`  ALU result
- `zero`  out  1  result == 0
- `illegal`  out  1  unsupported funct7/funct3 combination

Behaviour:
- Reset is asynchronous, active-low on `nreset`; clock is `clk`.
- Reset values: state IDLE, `in_ready`=1, `out_valid`=0, `result`=0, `zero`=1, `illegal`=0.
- Reset mid-operation aborts any shift or pending result and returns to IDLE.
- Accept: a request is taken on a rising edge where `in_valid` && `in_ready`. `in_ready` = (state==IDLE).
- States and transitions:
  - IDLE: on accept, go to SHIFT for funct3 001/101 when `alu_op` is 1x; otherwise compute and go to DONE.
  - SHIFT: load `result`=`op_a`, `cnt`=`op_b[4:0]`. Each cycle with `cnt`!=0, shift 1 bit and decrement `cnt`. When `cnt`==0, go to DONE.
  - DONE: `out_valid`=1. On `out_ready`, go to IDLE.
- Latency, edges from accept to `out_valid` high:
  - Non-shift ops: 1.
  - Shifts: 1 + shamt. shamt=0 gives 1 edge, 31 gives 32 edges.
- `alu_op` 00: `op_a`+`op_b`. `alu_op` 01: `op_a`−`op_b`. Both modulo 2^32, `funct3`/`funct7` ignored.
- `alu_op` 10 (R) / 11 (I), by `funct3`:
  - 000: ADD; SUB only when R and `funct7`=0100000.
  - 001: SLL.
  - 010: SLT (signed).
  - 011: SLTU.
  - 100: XOR.
  - 101: SRL, or SRA when `funct7[5]`=1.
  - 110: OR.
  - 111: AND.
- SRA shifts in `op_a[31]` each step. SLT/SLTU produce 0 or 1, zero-extended.
- `illegal`=1 (result forced to 0, still completes with 1-cycle latency) when:
  - R-type `funct7` ∉ {0000000, 0100000};
  - `funct7`=0100000 with `funct3` ∉ {000, 101};
  - I-type shift with `funct7` ∉ {0000000, 0100000};
  - SLLI with `funct7`=0100000.
  - I-type `funct7` is not checked for non-shift `funct3`.
- Outputs `result`/`zero`/`illegal` are registered and held stable while `out_valid` && !`out_ready`.
- `zero` is updated together with `result`.
- Inputs are sampled only at accept; changes afterwards are ignored.
- No back-to-back acceptance in DONE: a new request waits one cycle after `out_ready`.

Optional Feature:
- Macro `ALU_EXEC_FAST_SHIFT_EN`.
- Defined: shifts use a combinational barrel shifter; all ops have 1-edge latency and the SHIFT state is unreachable.
- Undefined: iterative shifter as above.

Decomposition:
- Package `alu_exec_pkg`:
  - `alu_op` encodings (`ALU_OP_ADD`/`SUB`/`R`/`I`);
  - `funct3` constants (`F3_ADD`…`F3_AND`);
  - `F7_BASE`=0000000, `F7_ALT`=0100000;
  - state enum {IDLE, SHIFT, DONE}.
- Sub-module `alu_exec_shifter`: iterative/barrel shifter with load, dir, arith, shamt, busy and done.
- The top level holds the FSM, decode and handshake.

Test Plan:
- Reset during SHIFT with shamt=20 at cycle 5 → `out_valid`=0, `in_ready`=1, `result`=0, `zero`=1. The next request is processed normally.
- `alu_op`=10, `funct3`=000, `funct7`=0100000, a=5, b=7 → `result`=0xFFFFFFFE after 1 edge, `zero`=0. `alu_op`=01, a=b=9 → `result`=0, `zero`=1.
- `alu_op`=10, `funct3`=101, `funct7`=0100000, a=0x80000000, b=31 → `result`=0xFFFFFFFF after 32 edges. The same with `funct7`=0 → 0x00000001.
- `alu_op`=11, `funct3`=001, b[4:0]=0, a=0x1234 → `result`=0x1234 after 1 edge. SLTU a=1, b=0xFFFFFFFF → 1. SLT with the same operands → 0.
- Backpressure: hold `out_ready`=0 for 10 cycles after `out_valid` → `result` stable and `in_ready`=0. Raise `out_ready` → IDLE next edge, then the next request is accepted.
- `alu_op`=10, `funct3`=100, `funct7`=0000001 → `illegal`=1, `result`=0, 1-edge latency. Rerun the shift tests with `ALU_EXEC_FAST_SHIFT_EN` → all latencies 1.
